// File: rtl/sparce_sasa_table.sv
// ----------------------------------------------------------------------------
// sparce_sasa_table
//
// Sparsity-Aware Skip Address (SASA) table for the SPARCE unit.
// Two-word entries (PC, then CFG) arrive on the execute configuration-store
// stream and are assembled by a two-state staging FSM. The fetch PC is looked
// up against all valid entries (fully associative). The registered result
// gives the skip target and the sparsity condition.
//
// Ports:
//   CLK        in   1   clock, rising edge
//   nRST       in   1   asynchronous active-low reset
//   sasa_wen   in   1   configuration store strobe
//   sasa_addr  in  32   store address (PC / CFG / CLEAR window)
//   sasa_data  in  32   store data
//   pc         in  32   fetch PC to look up
//   lookup_en  in   1   pipeline advance; result register loads when high
//   hit        out  1   registered: pc matched a valid entry
//   target     out 32   registered skip target (0 on miss)
//   rs1, rs2   out  5   registered condition source registers (0 on miss)
//   cond       out  2   registered condition code (0 on miss)
//   full       out  1   all entries valid
//
// Configuration macro:
//   SASA_FWD_EN  forward a same-cycle commit into the lookup result, and force
//                a miss on a same-cycle CLEAR.
// ----------------------------------------------------------------------------
module sparce_sasa_table #(
  parameter int          SASA_ENTRIES = 8,
  parameter logic [31:0] SASA_ADDR    = 32'h0000_1000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        sasa_wen,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  input  logic [31:0] pc,
  input  logic        lookup_en,
  output logic        hit,
  output logic [31:0] target,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [1:0]  cond,
  output logic        full
);

  localparam int IDX_W = $clog2(SASA_ENTRIES);

  typedef enum logic {
    ST_IDLE,
    ST_STAGED
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  cond;
  } entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic [31:0]             r_staged_pc;
  logic [SASA_ENTRIES-1:0] r_valid;
  entry_t                  r_entry [SASA_ENTRIES];
  logic [IDX_W-1:0]        r_alloc;

  logic        r_hit;
  logic [31:0] r_target;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [1:0]  r_cond;

  // --------------------------------------------------------------------------
  // Window decode
  // --------------------------------------------------------------------------
  logic w_pc_wr;
  logic w_cfg_wr;
  logic w_clr;

  assign w_pc_wr  = sasa_wen && (sasa_addr == SASA_ADDR);
  assign w_cfg_wr = sasa_wen && (sasa_addr == SASA_ADDR + 32'd4);
  assign w_clr    = sasa_wen && (sasa_addr == SASA_ADDR + 32'd8);

  // Bits of the CFG word above the skip count carry no meaning.
  logic w_unused;
  assign w_unused = ^sasa_data[31:22];

  // New entry assembled from the staged PC and the incoming CFG word.
  // The skip count is 10 bits, so n<<2 fits in 12 bits; the sum wraps mod 2^32.
  entry_t w_new;
  always_comb begin
    w_new        = '0;
    w_new.pc     = r_staged_pc;
    w_new.target = r_staged_pc + 32'd4 + {20'd0, sasa_data[21:12], 2'b00};
    w_new.rs1    = sasa_data[4:0];
    w_new.rs2    = sasa_data[9:5];
    w_new.cond   = sasa_data[11:10];
  end

  // --------------------------------------------------------------------------
  // Staging FSM
  // --------------------------------------------------------------------------
  state_t w_state_nxt;
  logic   w_commit;
  logic   w_latch_pc;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_latch_pc  = 1'b0;
    if (w_clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pc_wr) begin
            w_latch_pc  = 1'b1;
            w_state_nxt = ST_STAGED;
          end
          // A CFG write with nothing staged is dropped.
        end
        ST_STAGED: begin
          if (w_pc_wr) begin
            w_latch_pc = 1'b1;
          end else if (w_cfg_wr) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_staged_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_pc) r_staged_pc <= sasa_data;
    end
  end

  // --------------------------------------------------------------------------
  // Commit target selection: overwrite a matching entry, else allocate.
  // --------------------------------------------------------------------------
  logic [SASA_ENTRIES-1:0] w_stage_match;
  logic                    w_stage_hit;
  logic [IDX_W-1:0]        w_stage_idx;
  logic [IDX_W-1:0]        w_wr_idx;
  logic [IDX_W-1:0]        w_alloc_inc;

  always_comb begin
    w_stage_hit = 1'b0;
    w_stage_idx = '0;
    for (int i = 0; i < SASA_ENTRIES; i++) begin
      w_stage_match[i] = r_valid[i] && (r_entry[i].pc == r_staged_pc);
      if (w_stage_match[i]) begin
        w_stage_hit = 1'b1;
        w_stage_idx = IDX_W'(i);
      end
    end
  end

  assign w_wr_idx    = w_stage_hit ? w_stage_idx : r_alloc;
  assign w_alloc_inc = (r_alloc == IDX_W'(SASA_ENTRIES - 1)) ? '0 : r_alloc + 1'b1;

  // NOTE: the entry storage is reset along with the valid bits; it is only a
  // handful of flops, and it keeps lost state from being observable after nRST.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      r_alloc <= '0;
      for (int i = 0; i < SASA_ENTRIES; i++) r_entry[i] <= '0;
    end else if (w_clr) begin
      r_valid <= '0;
      r_alloc <= '0;
    end else if (w_commit) begin
      r_entry[w_wr_idx] <= w_new;
      r_valid[w_wr_idx] <= 1'b1;
      if (!w_stage_hit) r_alloc <= w_alloc_inc;
    end
  end

  assign full = &r_valid;

  // --------------------------------------------------------------------------
  // Lookup: pc entries are unique, so at most one match; OR-reduce the hits.
  // --------------------------------------------------------------------------
  logic   w_lk_hit;
  entry_t w_lk_entry;

  always_comb begin
    w_lk_hit   = 1'b0;
    w_lk_entry = '0;
    for (int i = 0; i < SASA_ENTRIES; i++) begin
      if (r_valid[i] && (r_entry[i].pc == pc)) begin
        w_lk_hit   = 1'b1;
        w_lk_entry = w_lk_entry | r_entry[i];
      end
    end
  end

  logic   w_res_hit;
  entry_t w_res;

  always_comb begin
    w_res_hit = w_lk_hit;
    w_res     = w_lk_entry;
`ifdef SASA_FWD_EN
    if (w_clr) begin
      w_res_hit = 1'b0;
      w_res     = '0;
    end else if (w_commit && (r_staged_pc == pc)) begin
      w_res_hit = 1'b1;
      w_res     = w_new;
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit    <= 1'b0;
      r_target <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_cond   <= '0;
    end else if (lookup_en) begin
      r_hit    <= w_res_hit;
      r_target <= w_res.target;
      r_rs1    <= w_res.rs1;
      r_rs2    <= w_res.rs2;
      r_cond   <= w_res.cond;
    end
  end

  assign hit    = r_hit;
  assign target = r_target;
  assign rs1    = r_rs1;
  assign rs2    = r_rs2;
  assign cond   = r_cond;

endmodule

// File: tb/tb_sparce_sasa_table.sv
// ----------------------------------------------------------------------------
// tb_sparce_sasa_table
//
// Directed scoreboard bench for sparce_sasa_table (SASA_ENTRIES=8,
// SASA_ADDR=0x1000). Lookups push their expected result into a queue; a
// monitor pops and compares on the falling edge after any edge where
// lookup_en was sampled high. Reset values and full are checked directly.
// ----------------------------------------------------------------------------
module tb_sparce_sasa_table;

  localparam logic [31:0] A_PC  = 32'h0000_1000;
  localparam logic [31:0] A_CFG = 32'h0000_1004;
  localparam logic [31:0] A_CLR = 32'h0000_1008;

  typedef struct packed {
    logic        hit;
    logic [31:0] target;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  cond;
  } res_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic [31:0] pc;
  logic        lookup_en;
  logic        hit;
  logic [31:0] target;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [1:0]  cond;
  logic        full;

  int n_tests = 0;
  int n_fail  = 0;

  res_t exp_q[$];

  sparce_sasa_table #(
    .SASA_ENTRIES(8),
    .SASA_ADDR   (32'h0000_1000)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .sasa_wen (sasa_wen),
    .sasa_addr(sasa_addr),
    .sasa_data(sasa_data),
    .pc       (pc),
    .lookup_en(lookup_en),
    .hit      (hit),
    .target   (target),
    .rs1      (rs1),
    .rs2      (rs2),
    .cond     (cond),
    .full     (full)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic lk_q;
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) lk_q <= 1'b0;
    else       lk_q <= lookup_en;
  end

  always @(negedge CLK) begin
    if (lk_q) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("hit",    {31'd0, hit}, {31'd0, e.hit});
        check("target", target,       e.target);
        check("rs1",    {27'd0, rs1}, {27'd0, e.rs1});
        check("rs2",    {27'd0, rs2}, {27'd0, e.rs2});
        check("cond",   {30'd0, cond}, {30'd0, e.cond});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] cfg_word(input int n, input int c, input int r2, input int r1);
    return {10'd0, 10'(n), 2'(c), 5'(r2), 5'(r1)};
  endfunction

  function automatic res_t mk(input logic [31:0] tgt, input int r1, input int r2, input int c);
    res_t r;
    r.hit = 1'b1; r.target = tgt; r.rs1 = 5'(r1); r.rs2 = 5'(r2); r.cond = 2'(c);
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    sasa_wen  = 1'b0;
    lookup_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sasa_wen = 1'b1; sasa_addr = a; sasa_data = d;
    step();
  endtask

  task automatic look(input logic [31:0] p, input res_t e);
    pc = p; lookup_en = 1'b1; exp_q.push_back(e);
    step();
  endtask

  task automatic commit(input logic [31:0] p, input logic [31:0] cfg);
    wr(A_PC, p);
    wr(A_CFG, cfg);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    res_t miss;
    res_t fwd_exp;
    miss = '0;
    nRST = 1'b0; sasa_wen = 1'b0; sasa_addr = '0; sasa_data = '0;
    pc = '0; lookup_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hit",    {31'd0, hit},  32'd0);
    check("reset_target", target,        32'd0);
    check("reset_full",   {31'd0, full}, 32'd0);
    nRST = 1'b1;
    step();

    // Empty table misses.
    look(32'h100, miss);

    // Basic commit and lookup.
    commit(32'h100, cfg_word(3, 2, 6, 5));
    look(32'h100, mk(32'h110, 5, 6, 2));
    look(32'h104, miss);

    // CFG write in IDLE is dropped: 0x100 keeps its original entry.
    wr(A_CFG, cfg_word(7, 1, 1, 1));
    look(32'h100, mk(32'h110, 5, 6, 2));

    // Second PC write replaces the staged PC.
    wr(A_PC, 32'h200);
    wr(A_PC, 32'h300);
    wr(A_CFG, cfg_word(0, 3, 4, 7));
    look(32'h300, mk(32'h304, 7, 4, 3));
    look(32'h200, miss);

    // Clear, then fill all 8 entries.
    wr(A_CLR, 32'h0);
    check("clear_full", {31'd0, full}, 32'd0);
    look(32'h100, miss);
    for (int i = 0; i < 8; i++) begin
      commit(32'h1000 + 32'(i * 16), cfg_word(i, i % 4, i + 8, i + 1));
      if (i == 6) check("full_at_7", {31'd0, full}, 32'd0);
    end
    check("full_at_8", {31'd0, full}, 32'd1);
    look(32'h1070, mk(32'h1090, 8, 15, 3));
    look(32'h1030, mk(32'h1040, 4, 11, 3));

    // 9th commit evicts entry 0 (0x1000).
    commit(32'h2000, cfg_word(5, 1, 2, 3));
    look(32'h1000, miss);
    look(32'h2000, mk(32'h2018, 3, 2, 1));

    // Recommit 0x1010: updated in place, alloc pointer stays at 1.
    commit(32'h1010, cfg_word(1, 0, 0, 9));
    look(32'h1010, mk(32'h1018, 9, 0, 0));
    commit(32'h3000, cfg_word(0, 0, 0, 0));
    look(32'h1010, miss);
    look(32'h1020, mk(32'h102c, 3, 10, 2));
    look(32'h3000, mk(32'h3004, 0, 0, 0));
    check("full_after_evict", {31'd0, full}, 32'd1);

    // Same-cycle commit and lookup.
    wr(A_CLR, 32'h0);
    wr(A_PC, 32'h400);
`ifdef SASA_FWD_EN
    fwd_exp = mk(32'h408, 2, 3, 1);
`else
    fwd_exp = miss;
`endif
    sasa_wen = 1'b1; sasa_addr = A_CFG; sasa_data = cfg_word(1, 1, 3, 2);
    pc = 32'h400; lookup_en = 1'b1; exp_q.push_back(fwd_exp);
    step();
    look(32'h400, mk(32'h408, 2, 3, 1));

    // Same-cycle CLEAR and lookup.
`ifdef SASA_FWD_EN
    fwd_exp = miss;
`else
    fwd_exp = mk(32'h408, 2, 3, 1);
`endif
    sasa_wen = 1'b1; sasa_addr = A_CLR; sasa_data = '0;
    pc = 32'h400; lookup_en = 1'b1; exp_q.push_back(fwd_exp);
    step();
    look(32'h400, miss);
    check("full_after_clear", {31'd0, full}, 32'd0);

    // Asynchronous reset between PC and CFG writes.
    commit(32'h600, cfg_word(2, 3, 1, 1));
    look(32'h600, mk(32'h60c, 1, 1, 3));
    wr(A_PC, 32'h500);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_hit",    {31'd0, hit}, 32'd0);
    check("async_rst_target", target,       32'd0);
    check("async_rst_cond",   {30'd0, cond}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step();
    wr(A_CFG, cfg_word(4, 0, 0, 0));
    look(32'h500, miss);
    look(32'h600, miss);

    repeat (2) @(posedge CLK);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
